// File: rtl/sorter_median_net.sv
// sorter_median_net
//   Pipelined odd-even transposition sorter. N lanes of WIDTH-bit unsigned
//   samples pass through N register stages. Stage s compare-exchanges the
//   lane pairs (i, i+1) whose index i has the same parity as s. The whole
//   pipeline advances together whenever the output is empty or being taken.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset, clears every stage
//   in_valid    input vector present
//   in_ready    pipeline advances this cycle (equals the advance signal)
//   in_desc     per-vector mode: 0 ascending, 1 descending
//   in_data     N lanes, lane k = in_data[k*WIDTH +: WIDTH]
//   out_valid   sorted vector present
//   out_ready   downstream accepts the output
//   out_data    sorted lanes, same packing as in_data
//   out_median  lane (N-1)/2 of out_data
//   out_desc    mode bit that travelled with out_data
module sorter_median_net #(
  parameter int WIDTH = 8,
  parameter int N     = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_desc,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [WIDTH-1:0]   out_median,
  output logic               out_desc
);

  localparam int MID = (N - 1) / 2;

  generate
    if (N < 3 || N > 15 || (N % 2) == 0) begin : g_bad_n
      $error("sorter_median_net: N must be odd and within 3..15");
    end
  endgenerate

  // One network stage: compare-exchange every pair (i, i+1) with i of the
  // given parity. Equal samples never swap, which keeps the sort stable.
  function automatic logic [N*WIDTH-1:0] cx_stage(
    input logic [N*WIDTH-1:0] v,
    input logic               desc,
    input int                 parity
  );
    logic [N*WIDTH-1:0] r;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    r = v;
    for (int i = 0; i + 1 < N; i++) begin
      if ((i % 2) == parity) begin
        a = v[i*WIDTH +: WIDTH];
        b = v[(i+1)*WIDTH +: WIDTH];
        if (desc ? (a < b) : (a > b)) begin
          r[i*WIDTH +: WIDTH]     = b;
          r[(i+1)*WIDTH +: WIDTH] = a;
        end
      end
    end
    return r;
  endfunction

  logic [N*WIDTH-1:0] data_q   [N];
  logic [N*WIDTH-1:0] data_d   [N];
  logic [N*WIDTH-1:0] src_data [N];
  logic [N-1:0]       valid_q, valid_d, src_valid;
  logic [N-1:0]       desc_q,  desc_d,  src_desc;
  logic               adv;

  // Global advance: no per-stage bubble collapse, the pipeline moves or
  // holds as a unit.
  assign adv      = !valid_q[N-1] || out_ready;
  assign in_ready = adv;

  // NOTE: every variable written here gets a value on every path (defaults
  // first, then overrides), so no latch can be inferred.
  always_comb begin
    src_data[0]  = in_data;
    src_valid[0] = in_valid;
    src_desc[0]  = in_desc;
    for (int s = 1; s < N; s++) begin
      src_data[s]  = data_q[s-1];
      src_valid[s] = valid_q[s-1];
      src_desc[s]  = desc_q[s-1];
    end
    for (int s = 0; s < N; s++) begin
      data_d[s]  = data_q[s];
      valid_d[s] = valid_q[s];
      desc_d[s]  = desc_q[s];
      if (adv) begin
        // Each stage sorts with the mode bit of the vector it holds, so
        // vectors of different modes never interact.
        data_d[s]  = cx_stage(src_data[s], src_desc[s], s % 2);
        valid_d[s] = src_valid[s];
        desc_d[s]  = src_desc[s];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage
  // samples its predecessor's pre-edge value. The data registers are reset
  // too (not only the valid bits) so the output reads all-zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < N; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
      desc_q  <= '0;
    end else begin
      for (int s = 0; s < N; s++) begin
        data_q[s] <= data_d[s];
      end
      valid_q <= valid_d;
      desc_q  <= desc_d;
    end
  end

  assign out_valid  = valid_q[N-1];
  assign out_data   = data_q[N-1];
  assign out_desc   = desc_q[N-1];
  assign out_median = data_q[N-1][MID*WIDTH +: WIDTH];

endmodule

// File: tb/tb_sorter_median_net.sv
// tb_sorter_median_net
//   Directed bench for sorter_median_net: a 9-lane 8-bit instance driven from
//   a vector table plus hand-written stall and reset sequences, and a 3-lane
//   16-bit instance for the wide-sample case.
module tb_sorter_median_net;

  localparam int N = 9;
  localparam int W = 8;

  typedef struct {
    string       name;
    logic [71:0] data;
    logic        desc;
    logic [71:0] exp_data;
    logic [7:0]  exp_med;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_desc;
  logic [71:0] in_data;
  logic        out_valid, out_ready, out_desc;
  logic [71:0] out_data;
  logic [7:0]  out_median;

  logic        s_in_valid, s_in_ready, s_in_desc;
  logic [47:0] s_in_data;
  logic        s_out_valid, s_out_ready, s_out_desc;
  logic [47:0] s_out_data;
  logic [15:0] s_out_median;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sorter_median_net #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_median(out_median), .out_desc(out_desc)
  );

  sorter_median_net #(.WIDTH(16), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_desc(s_in_desc), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_median(s_out_median), .out_desc(s_out_desc)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pack nine lane values, lane 0 first.
  function automatic logic [71:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // Reference sort: plain selection sort on the unpacked lanes.
  function automatic logic [71:0] ref_sort(input logic [71:0] v, input logic desc);
    logic [7:0]  a [9];
    logic [7:0]  t;
    logic [71:0] r;
    for (int k = 0; k < 9; k++) a[k] = v[k*8 +: 8];
    for (int i = 0; i < 9; i++) begin
      for (int j = i + 1; j < 9; j++) begin
        if (desc ? (a[j] > a[i]) : (a[j] < a[i])) begin
          t = a[i]; a[i] = a[j]; a[j] = t;
        end
      end
    end
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = a[k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one vector for a single cycle, then check it is absent after
  // N-1 edges and present, sorted, after exactly N edges.
  task automatic run_vec(input vec_t v);
    in_data  = v.data;
    in_desc  = v.desc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (N - 2) @(posedge clk);
    @(negedge clk);
    check({v.name, "_early"}, out_valid, 1'b0);
    tick();
    check({v.name, "_valid"}, out_valid, 1'b1);
    check({v.name, "_data"},  out_data,  v.exp_data);
    check({v.name, "_med"},   out_median, v.exp_med);
    check({v.name, "_desc"},  out_desc,  v.desc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [6];
    logic [71:0] rv  [20];
    logic        rd  [20];
    logic [72:0] expq [$];
    logic [72:0] held;
    logic [72:0] e;
    logic        held_ok;
    logic [71:0] a_vec;
    int          sent, got, cyc;

    tbl[0] = '{"asc_rev",  mk(9,8,7,6,5,4,3,2,1), 1'b0, mk(1,2,3,4,5,6,7,8,9), 8'd5};
    tbl[1] = '{"desc_rev", mk(9,8,7,6,5,4,3,2,1), 1'b1, mk(9,8,7,6,5,4,3,2,1), 8'd5};
    tbl[2] = '{"extremes", mk(255,0,255,0,255,0,255,0,128), 1'b0,
               mk(0,0,0,0,128,255,255,255,255), 8'd128};
    tbl[3] = '{"extr_desc", mk(255,0,255,0,255,0,255,0,128), 1'b1,
               mk(255,255,255,255,128,0,0,0,0), 8'd128};
    tbl[4] = '{"all_eq",   mk(60,60,60,60,60,60,60,60,60), 1'b0,
               mk(60,60,60,60,60,60,60,60,60), 8'h3C};
    tbl[5] = '{"mixed",    mk(3,200,17,17,90,0,255,42,1), 1'b0,
               mk(0,1,3,17,17,42,90,200,255), 8'd17};

    rst_n = 1'b0;  in_valid = 1'b0;  in_desc = 1'b0;  in_data = '0;  out_ready = 1'b1;
    s_in_valid = 1'b0;  s_in_desc = 1'b0;  s_in_data = '0;  s_out_ready = 1'b1;
    @(negedge clk);

    // Reset state, observed after a reset edge.
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  72'd0);
    check("rst_out_med",   out_median, 8'd0);
    check("rst_out_desc",  out_desc,  1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 1'b1);

    // Directed table.
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    tick();

    // Back-to-back vectors of opposite modes.
    in_data = mk(9,8,7,6,5,4,3,2,1);
    in_desc = 1'b0;  in_valid = 1'b1;
    tick();
    in_desc = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("b2b_asc_valid", out_valid, 1'b1);
    check("b2b_asc_data",  out_data,  mk(1,2,3,4,5,6,7,8,9));
    check("b2b_asc_desc",  out_desc,  1'b0);
    tick();
    check("b2b_desc_valid", out_valid, 1'b1);
    check("b2b_desc_data",  out_data,  mk(9,8,7,6,5,4,3,2,1));
    check("b2b_desc_desc",  out_desc,  1'b1);
    tick();
    check("b2b_drained", out_valid, 1'b0);

    // 3-lane, 16-bit instance.
    s_in_data  = {16'h8000, 16'h0001, 16'hFFFF};
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    tick();
    check("n3_early", s_out_valid, 1'b0);
    tick();
    check("n3_valid", s_out_valid, 1'b1);
    check("n3_data",  s_out_data,  {16'hFFFF, 16'h8000, 16'h0001});
    check("n3_med",   s_out_median, 16'h8000);
    check("n3_desc",  s_out_desc,  1'b0);
    tick();

    // Random stream with a 5-cycle output stall.
    for (int i = 0; i < 20; i++) begin
      rv[i] = {$urandom(), $urandom(), $urandom()};
      rd[i] = 1'($urandom_range(1, 0));
    end
    sent = 0;  got = 0;  cyc = 0;  held_ok = 1'b0;  held = '0;
    while (got < 20 && cyc < 300) begin
      out_ready = !(cyc >= 14 && cyc < 19);
      in_valid  = (sent < 20);
      if (sent < 20) begin
        in_data = rv[sent];
        in_desc = rd[sent];
      end
      #1;
      if (!out_ready) begin
        check("stall_in_ready", in_ready, 1'b0);
        check("stall_valid", out_valid, 1'b1);
        if (held_ok) check("stall_hold", {out_desc, out_data}, held);
        held    = {out_desc, out_data};
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (in_valid && in_ready) begin
        expq.push_back({rd[sent], ref_sort(rv[sent], rd[sent])});
        sent++;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("stream_unexpected", out_valid, 1'b0);
        end else begin
          e = expq.pop_front();
          check("stream_vec", {out_desc, out_data}, e);
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", got, 20);
    check("stream_left", expq.size(), 0);
    tick();

    // Reset in mid-flight: three vectors in, reset on the fourth edge with
    // in_valid still high.
    for (int k = 0; k < 3; k++) begin
      in_data  = mk(k, 7, 1, 9, 4, 2, 8, 3, 6);
      in_desc  = 1'b0;
      in_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    in_data = mk(5,5,5,5,5,5,5,5,5);
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data",  out_data,  72'd0);
    check("midrst_ready", in_ready,  1'b1);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("midrst_quiet", out_valid, 1'b0);
    end
    a_vec = mk(50, 10, 90, 30, 70, 20, 80, 40, 60);
    run_vec('{"post_rst", a_vec, 1'b1, mk(90,80,70,60,50,40,30,20,10), 8'd50});
    tick();
    check("final_empty", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sorter_median_net.md
SORTER_MEDIAN_NET -- requirements
Module: sorter_median_net

Interface
REQ-001 Parameter WIDTH, default 8, bit width of one sample (unsigned).
REQ-002 Parameter N, default 9, number of input lanes; legal values are odd 3..15; elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  input vector present.
REQ-006 in_ready  output  1  block can accept input this cycle.
REQ-007 in_desc  input  1  sort mode for this vector: 0 ascending, 1 descending.
REQ-008 in_data  input  N*WIDTH  lane k = in_data[k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  sorted vector present.
REQ-010 out_ready  input  1  downstream accepts output.
REQ-011 out_data  output  N*WIDTH  sorted lanes, same lane packing as in_data.
REQ-012 out_median  output  WIDTH  equals out_data lane (N-1)/2.
REQ-013 out_desc  output  1  mode bit travelling with out_data.

Function
REQ-014 The block SHALL implement an N-stage odd-even transposition network, one register stage per network stage; stage s compares lane pairs (i, i+1) for all i with i mod 2 = s mod 2.
REQ-015 Ascending: swap pair only if lane i > lane i+1 (strict); descending: swap only if lane i < lane i+1 (strict); equal values never swap, so ordering is stable.
REQ-016 Each stage SHALL carry a valid bit and the vector's desc bit; a mode bit never mixes between vectors.
REQ-017 Advance signal adv = !out_valid || out_ready; in_ready SHALL equal adv combinationally.
REQ-018 When adv = 1, every stage loads from its predecessor, stage 0 loads in_data/in_desc with valid = in_valid.
REQ-019 When adv = 0, all stage data, valid and desc registers SHALL hold; no bubble collapse.
REQ-020 Latency: a vector accepted at edge t with no stall appears on out_* with out_valid = 1 after edge t+N (N registered stages, out_* driven from the last stage).
REQ-021 Throughput: one vector per cycle while out_ready = 1.
REQ-022 out_data, out_median, out_desc SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-023 Simultaneous out_valid & out_ready & in_valid: output retires and input enters the same edge.
REQ-024 Bubbles (invalid stages) SHALL shift with the pipeline; their data is don't-care but must not raise out_valid.
REQ-025 Comparisons are unsigned WIDTH-bit; no width growth, no saturation.

Reset
REQ-026 With rst_n = 0 at an edge, all stage valid bits, desc bits and data registers SHALL clear to 0; thus out_valid = 0, out_data = 0, out_median = 0, out_desc = 0 after that edge.
REQ-027 in_ready SHALL be 1 in the first cycle after reset (pipeline empty).
REQ-028 Reset mid-operation discards all in-flight vectors; none SHALL appear at the output afterwards.
REQ-029 in_valid during a reset edge is ignored.

Verification (N=9, WIDTH=8)
REQ-030 Lanes 0..8 = 9,8,7,6,5,4,3,2,1, in_desc=0, out_ready=1 -> 9 edges later out_valid=1, lanes 0..8 = 1..9, out_median=5, out_desc=0.
REQ-031 Same vector with in_desc=1 -> lanes 0..8 = 9..1, out_median=5, out_desc=1; then ascending and descending vectors back-to-back -> each emerges with its own mode on consecutive cycles.
REQ-032 Lanes = 255,0,255,0,255,0,255,0,128 ascending -> lanes 0,0,0,0,128,255,255,255,255, out_median=128; all-equal 0x3C vector -> output all 0x3C, median 0x3C.
REQ-033 Stream 20 random vectors, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during stall, output held stable, no vector lost or duplicated, results match a reference sort in order.
REQ-034 Accept 3 vectors, assert rst_n=0 for one edge at cycle 4 -> out_valid stays 0 for the following 9 cycles; next accepted vector emerges exactly 9 edges later and correct.
REQ-035 Repeat REQ-030 with N=3, WIDTH=16, lanes 0xFFFF,0x0001,0x8000 -> after 3 edges output 0x0001,0x8000,0xFFFF, median 0x8000.
